// File: rtl/stft_frame_sequencer.sv
// Walks the circular sample buffer as NUM_FRAMES overlapping frames, one read address per beat.
// Tick-to-first-address latency is one cycle; outputs hold while iREADY is low.
module stft_frame_sequencer #(
    parameter int AW         = 12,
    parameter int FRAME_LEN  = 256,
    parameter int HOP        = 128,
    parameter int NUM_FRAMES = 31
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iTICK,
    input  logic [AW-1:0]                iBASE,
    input  logic                         iABORT,
    input  logic                         iREADY,
    output logic                         oVALID,
    output logic [AW-1:0]                oADDR,
    output logic [$clog2(FRAME_LEN)-1:0] oIDX,
    output logic [9:0]                   oFRAME,
    output logic                         oSOF,
    output logic                         oEOF,
    output logic                         oBUSY,
    output logic                         oDONE,
    output logic                         oOVR
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam logic [IW-1:0] IDX_LAST   = IW'(FRAME_LEN - 1);
    localparam logic [9:0]    FRAME_LAST = 10'(NUM_FRAMES - 1);
    localparam logic [AW-1:0] HOP_W      = AW'(HOP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [9:0]      frame_q, frame_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovr_q, ovr_d;
    logic [IW-1:0]   idx_inc;
    logic [AW-1:0]   base_hop;

    assign idx_inc  = idx_q + IW'(1);
    assign base_hop = base_q + HOP_W;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eof_d   = eof_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (iTICK && !iABORT) begin
                    state_d = RUN;
                    base_d  = iBASE;
                    addr_d  = iBASE;
                    idx_d   = '0;
                    frame_d = '0;
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    eof_d   = 1'b0;
                    busy_d  = 1'b1;
                    ovr_d   = 1'b0;
                end
            end
            RUN: begin
                if (iTICK) ovr_d = 1'b1;
                if (iABORT) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    idx_d   = '0;
                    frame_d = '0;
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eof_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (iREADY) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d  = idx_inc;
                        addr_d = base_q + AW'(idx_inc);
                        sof_d  = 1'b0;
                        eof_d  = (idx_inc == IDX_LAST);
                    end else if (frame_q != FRAME_LAST) begin
                        // Next frame starts on the very next beat, no bubble.
                        idx_d   = '0;
                        frame_d = frame_q + 10'd1;
                        base_d  = base_hop;
                        addr_d  = base_hop;
                        sof_d   = 1'b1;
                        eof_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                        addr_d  = '0;
                        idx_d   = '0;
                        frame_d = '0;
                        valid_d = 1'b0;
                        sof_d   = 1'b0;
                        eof_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (iTICK) ovr_d = 1'b1;
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign oVALID = valid_q;
    assign oADDR  = addr_q;
    assign oIDX   = idx_q;
    assign oFRAME = frame_q;
    assign oSOF   = sof_q;
    assign oEOF   = eof_q;
    assign oBUSY  = busy_q;
    assign oDONE  = done_q;
    assign oOVR   = ovr_q;
endmodule

// File: tb/tb_stft_frame_sequencer.sv
// Bench for stft_frame_sequencer: expected beats come from a per-pass list built by nested frame/sample loops.
module tb_stft_frame_sequencer;
    localparam int AW = 4;
    localparam int FL = 4;
    localparam int HP = 2;
    localparam int NF = 3;
    localparam int IW = $clog2(FL);

    logic          iCLK = 1'b0;
    logic          iRST, iTICK, iABORT, iREADY;
    logic [AW-1:0] iBASE;
    logic          oVALID, oSOF, oEOF, oBUSY, oDONE, oOVR;
    logic [AW-1:0] oADDR;
    logic [IW-1:0] oIDX;
    logic [9:0]    oFRAME;

    int   n_cmp = 0;
    int   n_err = 0;
    logic ovr_exp = 1'b0;

    stft_frame_sequencer #(.AW(AW), .FRAME_LEN(FL), .HOP(HP), .NUM_FRAMES(NF)) dut (
        .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK), .iBASE(iBASE), .iABORT(iABORT),
        .iREADY(iREADY), .oVALID(oVALID), .oADDR(oADDR), .oIDX(oIDX), .oFRAME(oFRAME),
        .oSOF(oSOF), .oEOF(oEOF), .oBUSY(oBUSY), .oDONE(oDONE), .oOVR(oOVR)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(oVALID), 0);
        chk({tag, ".addr"},  32'(oADDR),  0);
        chk({tag, ".idx"},   32'(oIDX),   0);
        chk({tag, ".frame"}, 32'(oFRAME), 0);
        chk({tag, ".sof"},   32'(oSOF),   0);
        chk({tag, ".eof"},   32'(oEOF),   0);
        chk({tag, ".busy"},  32'(oBUSY),  0);
        chk({tag, ".done"},  32'(oDONE),  0);
        chk({tag, ".ovr"},   32'(oOVR),   0);
    endtask

    // mode: 0 always ready, 1 ready pattern 1,0,0 repeating, 2 random ready.
    // *_beat: 0-based beat index where a late tick / abort / reset is injected (-1 = never).
    task automatic run_pass(input logic [AW-1:0] base, input int mode,
                            input int ovr_beat, input int abort_beat, input int rst_beat);
        logic [AW-1:0] ea[$];
        int            ei[$];
        int            ef[$];
        int            total, k, cyc;
        logic          rdy;
        bit            tick_sent, abort_sent, rst_sent;
        for (int f = 0; f < NF; f++)
            for (int i = 0; i < FL; i++) begin
                ea.push_back(AW'(int'(base) + f * HP + i));
                ei.push_back(i);
                ef.push_back(f);
            end
        total = FL * NF;
        tick_sent = 0; abort_sent = 0; rst_sent = 0;
        iBASE = base; iTICK = 1'b1; iABORT = 1'b0;
        step();
        iTICK = 1'b0;
        iBASE = AW'($urandom);
        ovr_exp = 1'b0;
        k = 0; cyc = 0;
        while (1) begin
            chk("valid", 32'(oVALID), 1);
            chk("addr",  32'(oADDR),  32'(ea[k]));
            chk("idx",   32'(oIDX),   32'(ei[k]));
            chk("frame", 32'(oFRAME), 32'(ef[k]));
            chk("sof",   32'(oSOF),   32'(ei[k] == 0));
            chk("eof",   32'(oEOF),   32'(ei[k] == FL - 1));
            chk("busy",  32'(oBUSY),  1);
            chk("done",  32'(oDONE),  0);
            chk("ovr",   32'(oOVR),   32'(ovr_exp));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            iREADY = rdy;
            if (k == ovr_beat && !tick_sent) begin iTICK = 1'b1; tick_sent = 1; end
            if (k == abort_beat && !abort_sent) begin iABORT = 1'b1; abort_sent = 1; end
            if (k == rst_beat && !rst_sent) begin iRST = 1'b1; rst_sent = 1; end
            step();
            cyc++;
            if (iTICK) ovr_exp = 1'b1;
            iTICK = 1'b0;
            if (iRST) begin
                iRST = 1'b0;
                ovr_exp = 1'b0;
                chk_all_zero("rst");
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("rst.idle_done",  32'(oDONE),  0);
                    chk("rst.idle_valid", 32'(oVALID), 0);
                end
                return;
            end
            if (iABORT) begin
                iABORT = 1'b0;
                chk("abort.valid", 32'(oVALID), 0);
                chk("abort.busy",  32'(oBUSY),  0);
                chk("abort.done",  32'(oDONE),  0);
                chk("abort.ovr",   32'(oOVR),   32'(ovr_exp));
                for (int j = 0; j < 3; j++) begin
                    step();
                    chk("abort.idle_done",  32'(oDONE),  0);
                    chk("abort.idle_valid", 32'(oVALID), 0);
                end
                return;
            end
            if (rdy) k++;
            if (k == total) begin
                chk("end.valid", 32'(oVALID), 0);
                chk("end.done",  32'(oDONE),  1);
                chk("end.busy",  32'(oBUSY),  1);
                chk("end.ovr",   32'(oOVR),   32'(ovr_exp));
                iREADY = 1'($urandom);
                step();
                chk("idle.done",  32'(oDONE),  0);
                chk("idle.busy",  32'(oBUSY),  0);
                chk("idle.valid", 32'(oVALID), 0);
                chk("idle.ovr",   32'(oOVR),   32'(ovr_exp));
                return;
            end
            if (cyc > 500) begin
                chk("timeout", 1, 0);
                return;
            end
        end
    endtask

    initial begin
        iRST = 1'b1; iTICK = 1'b0; iABORT = 1'b0; iREADY = 1'b0; iBASE = '0;
        step();
        step();
        chk_all_zero("reset");
        iRST = 1'b0;
        step();
        chk_all_zero("post_reset");

        run_pass(4'd0,  0, -1, -1, -1);
        run_pass(4'd14, 0, -1, -1, -1);
        run_pass(4'd5,  1, -1, -1, -1);
        run_pass(4'd3,  0,  4, -1, -1);
        run_pass(4'd0,  0, -1, -1, -1);
        run_pass(4'd0,  0, -1,  5, -1);
        run_pass(4'd8,  0, -1, -1, -1);
        run_pass(4'd2,  2, -1, -1,  6);

        iTICK = 1'b1; iABORT = 1'b1; iBASE = 4'd7;
        step();
        iTICK = 1'b0; iABORT = 1'b0;
        chk("tick_abort.valid", 32'(oVALID), 0);
        chk("tick_abort.busy",  32'(oBUSY),  0);
        step();
        chk("tick_abort.valid2", 32'(oVALID), 0);

        run_pass(4'd9, 2, 3, 3, -1);
        run_pass(4'd1, 0, -1, -1, -1);

        for (int r = 0; r < 8; r++)
            run_pass(AW'($urandom), 2, int'($urandom_range(0, 15)), -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
